seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU, sitting between the A/B operand registers and the Z register (ZHI/ZLO).
- Keeps the existing 5-bit opcode encoding.
- Logic, shift and add ops complete in one cycle. MUL uses iterative radix-2 Booth; DIV uses iterative non-restoring signed division.
- Uses a start/done/busy handshake so the control unit can stall on long operations.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 225 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result bundle between the control unit and seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [4:0]         ops;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;
  logic               done;
  logic               busy;
  logic               zero;
  logic               div_by_zero;
  logic               illegal_op;

  modport master (
    output start, ops, a, b,
    input  result, done, busy, zero, div_by_zero, illegal_op
  );

  modport slave (
    input  start, ops, a, b,
    output result, done, busy, zero, div_by_zero, illegal_op
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle logic/shift/add, radix-2 Booth MUL, non-restoring DIV
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     clr,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {s_idle, s_mul, s_div, s_div_fix, s_done} state_t;
  state_t state, state_nxt;

  // acc is one bit wider than the operands so Booth's A-M and the divider's
  // partial remainder never overflow, even for the most-negative operand
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   qr;
  logic [WIDTH-1:0]   mreg;
  logic               qm1;
  logic [SHW-1:0]     cnt;
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] result_q;
  logic               zero_q;
  logic               dbz_q;
  logic               ill_q;

  logic [SHW-1:0]     amt;
  logic [SHW:0]       inv_amt;
  logic [WIDTH-1:0]   single_res;
  logic               single_ok;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               last;

  assign amt     = bus.b[SHW-1:0];
  assign inv_amt = (SHW+1)'(WIDTH) - {1'b0, amt};
  assign a_mag   = bus.a[WIDTH-1] ? '0 - bus.a : bus.a;
  assign b_mag   = bus.b[WIDTH-1] ? '0 - bus.b : bus.b;
  assign last    = (cnt == SHW'(WIDTH - 1));

  always_comb begin
    single_res = '0;
    single_ok  = 1'b1;
    case (bus.ops)
      5'b00000, 5'b00001, 5'b00010, 5'b00011: single_res = bus.a + bus.b;
      OP_SUB:  single_res = bus.a - bus.b;
      OP_AND:  single_res = bus.a & bus.b;
      OP_OR:   single_res = bus.a | bus.b;
      OP_NOT:  single_res = ~bus.a;
      OP_NEG:  single_res = '0 - bus.a;
      OP_SHR:  single_res = bus.a >> amt;
      OP_SHRA: single_res = $signed(bus.a) >>> amt;
      OP_SHL:  single_res = bus.a << amt;
      // a shift by the full width yields 0, so amount 0 passes a unchanged
      OP_ROR:  single_res = (bus.a >> amt) | (bus.a << inv_amt);
      OP_ROL:  single_res = (bus.a << amt) | (bus.a >> inv_amt);
      default: single_ok = 1'b0;
    endcase
  end

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     booth_acc_nxt;
  logic [WIDTH-1:0]   booth_q_nxt;

  assign m_ext = {mreg[WIDTH-1], mreg};

  always_comb begin
    booth_sum = acc;
    case ({qr[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  assign booth_acc_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_q_nxt   = {booth_sum[0], qr[WIDTH-1:1]};

  logic [WIDTH:0]     d_ext;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     div_acc_nxt;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign d_ext       = {1'b0, mreg};
  assign r_sh        = {acc[WIDTH-1:0], qr[WIDTH-1]};
  assign div_acc_nxt = acc[WIDTH] ? r_sh + d_ext : r_sh - d_ext;
  // a negative final partial remainder still owes one divisor back
  assign rem_mag     = acc[WIDTH] ? acc[WIDTH-1:0] + mreg : acc[WIDTH-1:0];
  assign quot_fix    = neg_q ? '0 - qr : qr;
  assign rem_fix     = neg_r ? '0 - rem_mag : rem_mag;

  logic               fin_we;
  logic [2*WIDTH-1:0] fin_res;
  logic               fin_dbz;
  logic               fin_ill;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= s_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin_we    = 1'b0;
    fin_res   = '0;
    fin_dbz   = 1'b0;
    fin_ill   = 1'b0;
    case (state)
      s_idle, s_done: begin
        state_nxt = s_idle;
        if (bus.start) begin
          if (bus.ops == OP_MUL) begin
            state_nxt = s_mul;
          end else if (bus.ops == OP_DIV && bus.b != '0) begin
            state_nxt = s_div;
          end else begin
            state_nxt = s_done;
            fin_we    = 1'b1;
            if (bus.ops == OP_DIV) begin
              fin_res = {bus.a, {WIDTH{1'b1}}};
              fin_dbz = 1'b1;
            end else if (single_ok) begin
              fin_res = {{WIDTH{1'b0}}, single_res};
            end else begin
              fin_ill = 1'b1;
            end
          end
        end
      end
      s_mul: begin
        if (last) begin
          state_nxt = s_done;
          fin_we    = 1'b1;
          fin_res   = {booth_acc_nxt[WIDTH-1:0], booth_q_nxt};
        end
      end
      s_div: begin
        if (last) state_nxt = s_div_fix;
      end
      s_div_fix: begin
        state_nxt = s_done;
        fin_we    = 1'b1;
        fin_res   = {rem_fix, quot_fix};
      end
      default: state_nxt = s_idle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc      <= '0;
      qr       <= '0;
      mreg     <= '0;
      qm1      <= 1'b0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (fin_we) begin
        result_q <= fin_res;
        zero_q   <= (fin_res == '0);
        dbz_q    <= fin_dbz;
        ill_q    <= fin_ill;
      end
      case (state)
        s_idle, s_done: begin
          if (bus.start) begin
            acc <= '0;
            qm1 <= 1'b0;
            cnt <= '0;
            if (bus.ops == OP_MUL) begin
              qr   <= bus.a;
              mreg <= bus.b;
            end else begin
              qr    <= a_mag;
              mreg  <= b_mag;
              neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              neg_r <= bus.a[WIDTH-1];
            end
          end
        end
        s_mul: begin
          acc <= booth_acc_nxt;
          qr  <= booth_q_nxt;
          qm1 <= qr[0];
          cnt <= cnt + 1'b1;
        end
        s_div: begin
          acc <= div_acc_nxt;
          qr  <= {qr[WIDTH-2:0], ~div_acc_nxt[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;
  assign bus.done        = (state == s_done);
  assign bus.busy        = (state == s_mul) || (state == s_div) || (state == s_div_fix);
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu at WIDTH 32 and 8
module tb_seq_alu;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) b32 ();
  seq_alu_if #(.WIDTH(8))  b8 ();

  seq_alu #(.WIDTH(32)) dut  (.clk(clk), .clr(clr), .bus(b32));
  seq_alu #(.WIDTH(8))  dut8 (.clk(clk), .clr(clr), .bus(b8));

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_res;
  logic [63:0] last_exp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // reference: plain integer arithmetic on sign-extended 64-bit values
  function automatic void model(input int w, input logic [4:0] op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res,
                                output bit dbz, output bit ill, output int lat);
    logic [63:0] mask;
    logic [63:0] mask2;
    logic [63:0] x;
    longint sa;
    longint sb;
    int amt;
    mask  = (64'd1 << w) - 64'd1;
    mask2 = {64{1'b1}} >> (64 - 2 * w);
    sa    = sx(a, w);
    sb    = sx(b, w);
    amt   = int'(b % 64'(w));
    res   = '0;
    dbz   = 1'b0;
    ill   = 1'b0;
    lat   = 1;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3: res = (a + b) & mask;
      5'd4:  res = (a - b) & mask;
      5'd10: res = a & b;
      5'd11: res = a | b;
      5'd18: res = ~a & mask;
      5'd17: res = (64'd0 - a) & mask;
      5'd5:  res = a >> amt;
      5'd6:  res = 64'(sa >>> amt) & mask;
      5'd7:  res = (a << amt) & mask;
      5'd8: begin
        x = a;
        for (int k = 0; k < amt; k++) x = (x >> 1) | ((x & 64'd1) << (w - 1));
        res = x;
      end
      5'd9: begin
        x = a;
        for (int k = 0; k < amt; k++) x = ((x << 1) | (x >> (w - 1))) & mask;
        res = x;
      end
      5'd15: begin
        res = 64'(sa * sb) & mask2;
        lat = w + 1;
      end
      5'd16: begin
        if (b == 64'd0) begin
          res = (a << w) | mask;
          dbz = 1'b1;
        end else begin
          res = ((64'(sa % sb) & mask) << w) | (64'(sa / sb) & mask);
          lat = w + 2;
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic drive(input bit w8, input bit st, input logic [4:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      b8.start = st; b8.ops = op; b8.a = a[7:0]; b8.b = b[7:0];
    end else begin
      b32.start = st; b32.ops = op; b32.a = a[31:0]; b32.b = b[31:0];
    end
  endtask

  // fl = {done, busy, zero, div_by_zero, illegal_op}
  task automatic sample(input bit w8, output logic [63:0] res, output logic [4:0] fl);
    if (w8) begin
      res = {56'd0, b8.result};
      fl  = {b8.done, b8.busy, b8.zero, b8.div_by_zero, b8.illegal_op};
    end else begin
      res = b32.result;
      fl  = {b32.done, b32.busy, b32.zero, b32.div_by_zero, b32.illegal_op};
    end
  endtask

  task automatic scramble(input bit w8);
    drive(w8, 1'b0, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // call at a negedge; returns at the negedge where done is first seen
  task automatic run_op(input bit w8, input string tag, input logic [4:0] op,
                        input logic [63:0] a, input logic [63:0] b, input int poke_at);
    int w;
    int lat;
    int exp_lat;
    logic [63:0] exp_res;
    logic [63:0] res;
    logic [4:0] fl;
    bit exp_dbz;
    bit exp_ill;
    w = w8 ? 8 : 32;
    model(w, op, a, b, exp_res, exp_dbz, exp_ill, exp_lat);
    drive(w8, 1'b1, op, a, b);
    @(posedge clk);
    lat = 1;
    #1 scramble(w8);
    @(negedge clk);
    sample(w8, res, fl);
    if (exp_lat > 1) check_eq({tag, "_busy"}, 64'(fl[3]), 64'd1);
    while (!fl[4] && lat < 200) begin
      if (poke_at != 0 && lat == poke_at && poke_at < exp_lat - 1)
        drive(w8, 1'b1, 5'b01010, {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk);
      lat++;
      #1 scramble(w8);
      @(negedge clk);
      sample(w8, res, fl);
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_res"}, res, exp_res);
    check_eq({tag, "_zero"}, 64'(fl[2]), 64'(exp_res == 64'd0));
    check_eq({tag, "_dbz"}, 64'(fl[1]), 64'(exp_dbz));
    check_eq({tag, "_ill"}, 64'(fl[0]), 64'(exp_ill));
    last_res = res;
    last_exp = exp_res;
  endtask

  task automatic idle(input bit w8, input int n);
    logic [63:0] res;
    logic [4:0] fl;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(w8, res, fl);
      check_eq("idle_done", 64'(fl[4]), 64'd0);
      check_eq("idle_busy", 64'(fl[3]), 64'd0);
      check_eq("idle_hold", res, last_exp);
    end
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return mask;
      3:       return 64'd1 << (w - 1);
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  initial begin
    logic [63:0] res;
    logic [4:0]  fl;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  op;
    bit w8;
    int w;
    int dones;

    clr = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    sample(1'b0, res, fl);
    check_eq("rst_res", res, 64'd0);
    check_eq("rst_flags", 64'(fl), 64'd0);
    sample(1'b1, res, fl);
    check_eq("rst8_res", res, 64'd0);
    check_eq("rst8_flags", 64'(fl), 64'd0);
    clr = 1'b0;
    @(negedge clk);

    run_op(1'b0, "add", 5'b00000, 64'h7FFFFFFF, 64'd1, 0);
    check_eq("tp_add", last_res, 64'h00000000_80000000);
    run_op(1'b0, "ror", 5'b01000, 64'd1, 64'd33, 0);
    check_eq("tp_ror", last_res, 64'h00000000_80000000);
    run_op(1'b0, "shra", 5'b00110, 64'h80000000, 64'd4, 0);
    check_eq("tp_shra", last_res, 64'h00000000_F8000000);
    idle(1'b0, 1);
    run_op(1'b0, "mul", 5'b01111, 64'hFFFFFFFD, 64'd7, 5);
    check_eq("tp_mul", last_res, 64'hFFFFFFFF_FFFFFFEB);
    run_op(1'b0, "div", 5'b10000, 64'hFFFFFFEF, 64'd5, 0);
    check_eq("tp_div", last_res, 64'hFFFFFFFE_FFFFFFFD);
    run_op(1'b0, "divmin", 5'b10000, 64'h80000000, 64'hFFFFFFFF, 0);
    check_eq("tp_divmin", last_res, 64'h00000000_80000000);
    run_op(1'b0, "div0", 5'b10000, 64'd100, 64'd0, 0);
    check_eq("tp_div0", last_res, 64'h00000064_FFFFFFFF);
    run_op(1'b0, "add_after_div0", 5'b00001, 64'd5, 64'd6, 0);
    run_op(1'b0, "ill", 5'b11000, 64'd3, 64'd4, 0);
    run_op(1'b0, "div0_pre_rst", 5'b10000, 64'h1234, 64'd0, 0);

    drive(1'b0, 1'b1, 5'b10000, 64'hFFFFFC18, 64'd7);
    @(posedge clk);
    #1 scramble(1'b0);
    repeat (10) @(posedge clk);
    #2 clr = 1'b1;
    #1 sample(1'b0, res, fl);
    check_eq("midrst_res", res, 64'd0);
    check_eq("midrst_flags", 64'(fl), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      sample(1'b0, res, fl);
      if (fl[4]) dones++;
    end
    check_eq("midrst_nodone", 64'(dones), 64'd0);
    run_op(1'b0, "mul_after_rst", 5'b01111, 64'h12345678, 64'hFEDCBA98, 0);

    run_op(1'b1, "mul8", 5'b01111, 64'h80, 64'h80, 0);
    check_eq("tp_mul8", last_res, 64'h4000);

    for (int i = 0; i < 300; i++) begin
      w8 = ($urandom_range(0, 3) == 0);
      w  = w8 ? 8 : 32;
      case ($urandom_range(0, 9))
        0, 1:    op = 5'b01111;
        2, 3:    op = 5'b10000;
        default: op = 5'($urandom_range(0, 31));
      endcase
      a = pick(w);
      b = pick(w);
      if (op == 5'b10000 && $urandom_range(0, 7) == 0) b = 64'd0;
      run_op(w8, "rnd", op, a, b, ($urandom_range(0, 3) == 0) ? 3 : 0);
      idle(w8, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
